// File: rtl/seq_det_ctrl_if.sv
// Control, configuration and status bundle of the programmable sequence detector.
// The master side drives stimulus and config; the slave side is the detector.
interface seq_det_ctrl_if #(
  parameter int MAXLEN = 8,
  parameter int CNT_W  = 8
);
  logic              in;
  logic              cfg_we;
  logic [MAXLEN-1:0] cfg_pattern;
  logic [3:0]        cfg_len;
  logic [CNT_W-1:0]  cfg_target;
  logic              start;
  logic              abort;
  logic              out;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  match_cnt;

  modport master (
    output in, cfg_we, cfg_pattern, cfg_len, cfg_target, start, abort,
    input  out, busy, done, match_cnt
  );

  modport slave (
    input  in, cfg_we, cfg_pattern, cfg_len, cfg_target, start, abort,
    output out, busy, done, match_cnt
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Programmable overlapping Mealy sequence detector with an IDLE/ARMED/DONE
// controller, a saturating match counter and stop-on-target.
module seq_det_ctrl #(
  parameter int MAXLEN = 8,
  parameter int CNT_W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  seq_det_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

  localparam logic [3:0]        LEN_MAX     = 4'(MAXLEN);
  localparam logic [MAXLEN-1:0] PATTERN_RST = MAXLEN'(8'h0D);

  state_t            state_q, state_d;
  logic [MAXLEN-1:0] pattern_q;
  logic [3:0]        len_q;
  logic [CNT_W-1:0]  target_q;
  logic [MAXLEN-2:0] hist_q;
  logic [3:0]        fill_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [MAXLEN-1:0] window;
  logic [MAXLEN-1:0] mask;
  logic [3:0]        len_in;
  logic              armed;
  logic              match;
  logic              hit;
  logic              reach;
  logic              cfg_ok;

  // Length is normalised once at write time so the detector only sees 1..MAXLEN.
  always_comb begin
    if (bus.cfg_len == 4'd0)         len_in = 4'd1;
    else if (bus.cfg_len > LEN_MAX)  len_in = LEN_MAX;
    else                             len_in = bus.cfg_len;
  end

  // The incoming bit is the newest pattern bit, so matching looks at hist plus in.
  assign window = {hist_q, bus.in};

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAXLEN; i++) mask[i] = (4'(i) < len_q);
  end

  assign armed  = (state_q == ARMED);
  assign match  = (fill_q >= len_q - 4'd1) && (((window ^ pattern_q) & mask) == '0);
  assign hit    = match && armed && !bus.abort;
  assign reach  = (target_q != '0) &&
                  (({1'b0, cnt_q} + (CNT_W+1)'(1)) == {1'b0, target_q});
  assign cfg_ok = bus.cfg_we && !armed;

  // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (bus.start) state_d = ARMED;
      ARMED: begin
        if (bus.abort)         state_d = IDLE;
        else if (hit && reach) state_d = DONE;
      end
      default:                 state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous here, so rst appears only inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= PATTERN_RST;
      len_q     <= 4'd4;
      target_q  <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
    end else begin
      if (cfg_ok) begin
        pattern_q <= bus.cfg_pattern;
        len_q     <= len_in;
        target_q  <= bus.cfg_target;
      end
      if (!armed && bus.start) begin
        hist_q <= '0;
        fill_q <= '0;
        cnt_q  <= '0;
      end else if (armed) begin
        hist_q <= window[MAXLEN-2:0];
        if (fill_q < len_q) fill_q <= fill_q + 4'd1;
        if (hit && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.out       = hit;
  assign bus.busy      = armed;
  assign bus.done      = (state_q == DONE);
  assign bus.match_cnt = cnt_q;

endmodule
